seg_scan_controller: RTL and testbench

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_glyph_rom.sv | 26 ++
 rtl/seg_scan_controller.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] GLYPH_0   = 7'h3F;
    localparam logic [6:0] GLYPH_1   = 7'h06;
    localparam logic [6:0] GLYPH_2   = 7'h5B;
    localparam logic [6:0] GLYPH_3   = 7'h4F;
    localparam logic [6:0] GLYPH_4   = 7'h66;
    localparam logic [6:0] GLYPH_5   = 7'h6D;
    localparam logic [6:0] GLYPH_6   = 7'h7D;
    localparam logic [6:0] GLYPH_7   = 7'h07;
    localparam logic [6:0] GLYPH_8   = 7'h7F;
    localparam logic [6:0] GLYPH_9   = 7'h6F;
    localparam logic [6:0] GLYPH_OFF = 7'h00;

    localparam logic [8:0] SEG_BLANK = 9'h000;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational BCD-to-seven-segment lookup; non-decimal codes produce a dark digit.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_OFF;
        case (digit)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment driver with tear-free double-buffered updates.
// Optional leading-zero suppression: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    output logic [8:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [2:0]            cur_digit
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

    scan_state_t         state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [2:0]          idx, idx_next;
    logic                frame_end;

    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_valid;
    logic                handshake;

    logic [3:0]          sel_nibble;
    logic                sel_dp;
    logic                sel_lz;
    logic [DIGITS-1:0]   lz_blank;
    logic [6:0]          glyph_raw;
    logic [6:0]          glyph_shown;

    logic [8:0]          seg_next;
    logic [DIGITS-1:0]   dig_sel_next;

    assign wr_ready  = !pend_valid;
    assign handshake = wr_valid && wr_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        frame_end  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    if (idx == IDX_LAST) begin
                        idx_next  = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digit i goes dark when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (shadow_data[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Outputs are precomputed for the upcoming state so the registered pins line up with it.
    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_lz     = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (3'(i) == idx_next) begin
                sel_nibble = shadow_data[4*i +: 4];
                sel_dp     = shadow_dp[i];
                sel_lz     = lz_blank[i];
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .digit (sel_nibble),
        .glyph (glyph_raw)
    );

    assign glyph_shown = sel_lz ? GLYPH_OFF : glyph_raw;

    always_comb begin
        seg_next     = SEG_BLANK;
        dig_sel_next = '1;
        if (state_next == ST_SHOW) begin
            seg_next = {1'b0, sel_dp, glyph_shown};
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (3'(i) == idx_next) begin
                    dig_sel_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            idx       <= '0;
            seg       <= SEG_BLANK;
            dig_sel   <= '1;
            cur_digit <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            seg       <= seg_next;
            dig_sel   <= dig_sel_next;
            cur_digit <= idx_next;
        end
    end

    // A handshake can only happen with pending empty, so it never collides with the frame-end drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                shadow_data <= pend_data;
                shadow_dp   <= pend_dp;
                pend_valid  <= 1'b0;
            end
            if (handshake) begin
                pend_data  <= wr_data;
                pend_dp    <= wr_dp;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller (4 digits, short scan timing); honours SEG_LEADING_ZERO_BLANK_EN.
module tb_seg_scan_controller;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [8:0]  seg;
    logic [3:0]  dig_sel;
    logic [2:0]  cur_digit;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .cur_digit (cur_digit)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [3:0] sel;
        logic [8:0] seg;
        logic [2:0] cur;
    } slot_t;

    slot_t sb[$];

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic void push_frame(input logic [15:0] w, input logic [3:0] dp);
        slot_t      tmp [4];
        logic       zero_above;
        logic [6:0] g;
        logic [3:0] sel;
        zero_above = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            g          = ref_glyph(w[4*i +: 4]);
            zero_above = zero_above && (w[4*i +: 4] == 4'h0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (i >= 1 && zero_above) g = 7'h00;
`endif
            sel        = 4'hF;
            sel[i]     = 1'b0;
            tmp[i].sel = sel;
            tmp[i].seg = {1'b0, dp[i], g};
            tmp[i].cur = 3'(i);
        end
        for (int i = 0; i < 4; i++) sb.push_back(tmp[i]);
    endfunction

    int    slots_seen = 0;
    int    blank_len  = 0;
    int    show_len   = 0;
    logic  in_show    = 1'b0;
    slot_t exp_slot;

    always @(negedge clk) begin
        if (!rst_n) begin
            blank_len  = 0;
            show_len   = 0;
            in_show    = 1'b0;
            slots_seen = 0;
        end else if (dig_sel == 4'hF) begin
            check("blank_seg", 32'(seg), 32'h0);
            if (in_show) begin
                check("show_len", show_len, SCAN_DIV);
                in_show   = 1'b0;
                blank_len = 0;
            end
            blank_len++;
        end else begin
            if (!in_show) begin
                check("blank_len", blank_len, BLANK_CYC);
                check("sb_depth", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) begin
                    exp_slot = sb.pop_front();
                    check($sformatf("slot%0d_dig_sel", slots_seen), 32'(dig_sel), 32'(exp_slot.sel));
                    check($sformatf("slot%0d_seg", slots_seen), 32'(seg), 32'(exp_slot.seg));
                    check($sformatf("slot%0d_cur_digit", slots_seen), 32'(cur_digit), 32'(exp_slot.cur));
                end
                in_show  = 1'b1;
                show_len = 0;
                slots_seen++;
            end else begin
                check("show_hold", {dig_sel, seg}, {exp_slot.sel, exp_slot.seg});
            end
            show_len++;
        end
    end

    task automatic wait_slots(input int n);
        int budget;
        budget = 2000;
        while (slots_seen < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check($sformatf("reach_slot%0d", n), 32'(slots_seen >= n), 32'h1);
    endtask

    task automatic write_word(input logic [15:0] d, input logic [3:0] dp, output int waited);
        waited   = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        while (waited < 200) begin
            @(negedge clk);
            if (wr_ready) break;
            waited++;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = 16'($urandom);
        wr_dp    = 4'($urandom);
        check("wr_accept", 32'(waited < 200), 32'h1);
    endtask

    initial begin
        int w;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'hFFFF;
        wr_dp    = 4'hF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dig_sel", 32'(dig_sel), 32'hF);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_cur_digit", 32'(cur_digit), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);

        push_frame(16'h0000, 4'h0);
        rst_n = 1'b1;

        // New word lands mid-frame; the frame in progress keeps the old value.
        wait_slots(2);
        write_word(16'h1234, 4'b0000, w);
        check("ready_low_after_1234", 32'(wr_ready), 32'h0);
        push_frame(16'h1234, 4'b0000);

        // Back-to-back: second word must wait for the boundary and show one frame later.
        wait_slots(5);
        write_word(16'h905A, 4'b0011, w);
        check("ready_low_after_A", 32'(wr_ready), 32'h0);
        push_frame(16'h905A, 4'b0011);
        write_word(16'h0045, 4'b0000, w);
        check("b_accept_slot", slots_seen, 8);
        check("b_waited", 32'(w > 0), 32'h1);
        push_frame(16'h0045, 4'b0000);
        push_frame(16'h0045, 4'b0000);

        // Queue a word, then reset in the middle of a SHOW slot.
        wait_slots(17);
        write_word(16'h7777, 4'b1111, w);
        wait_slots(18);
        @(posedge clk);
        #2;
        check("pre_rst_showing", 32'(dig_sel != 4'hF), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_dig_sel", 32'(dig_sel), 32'hF);
        check("async_rst_seg", 32'(seg), 32'h0);
        check("async_rst_cur_digit", 32'(cur_digit), 32'h0);
        check("async_rst_wr_ready", 32'(wr_ready), 32'h1);
        sb.delete();
        push_frame(16'h0000, 4'h0);
        push_frame(16'h0000, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        wait_slots(8);
        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
